ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Multiply/divide unit bus: operation request, HI/LO move-to writes, flush and results.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mthi;
  logic             mtlo;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle on operand magnitudes, sign fix-up in a final cycle.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_muldiv_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;    // dividend as issued, for divide-by-zero HI
  logic [WIDTH-1:0]  b_mag_q, b_mag_d;
  logic              q_neg_q, q_neg_d;    // product/quotient sign
  logic              r_neg_q, r_neg_d;    // remainder sign (dividend sign)
  logic [AccW-1:0]   acc_q, acc_d;        // mul: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  logic              op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH-1:0]  mul_addend;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    rem_sh, rem_diff;
  logic              rem_ge;
  logic [AccW-1:0]   prod_s;
  logic [WIDTH-1:0]  quo_s, rem_s;

  // Operand sign/magnitude decode and datapath step/fix-up arithmetic
  always_comb begin
    op_signed  = ~bus.op[0];
    a_neg      = op_signed & bus.src_a[WIDTH-1];
    b_neg      = op_signed & bus.src_b[WIDTH-1];
    a_mag      = a_neg ? -bus.src_a : bus.src_a;
    b_mag      = b_neg ? -bus.src_b : bus.src_b;
    mul_addend = acc_q[0] ? b_mag_q : '0;
    mul_sum    = {1'b0, acc_q[AccW-1:WIDTH]} + {1'b0, mul_addend};
    rem_sh     = acc_q[AccW-1:WIDTH-1];
    rem_ge     = rem_sh >= {1'b0, b_mag_q};
    rem_diff   = rem_sh - {1'b0, b_mag_q};
    prod_s     = q_neg_q ? -acc_q : acc_q;
    quo_s      = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s      = r_neg_q ? -acc_q[AccW-1:WIDTH] : acc_q[AccW-1:WIDTH];
  end

  // Next-state: issue, iterate, fix up, plus HI/LO move-to writes and flush
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_raw_d  = a_raw_q;
    b_mag_d  = b_mag_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus.flush) begin
          if (bus.start) begin
            state_d  = StRun;
            cnt_d    = CntW'(WIDTH);
            is_div_d = bus.op[1];
            a_raw_d  = bus.src_a;
            b_mag_d  = b_mag;
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
          end else begin
            if (bus.mthi) hi_d = bus.src_a;
            if (bus.mtlo) lo_d = bus.src_a;
          end
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            // Restoring step: the dropped top bit of rem_diff is always zero here
            acc_d = rem_ge ? AccW'({rem_diff, acc_q[WIDTH-2:0], 1'b1})
                           : {acc_q[AccW-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_s;
          end else if (b_mag_q == '0) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            // Most-negative / -1 falls out of the magnitude path as {0, most-negative}
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_raw_q  <= a_raw_d;
      b_mag_q  <= b_mag_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32): directed vectors, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_ex_muldiv;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sp;
    int     sa, sb;
    case (op)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'd1: return {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
          sa = a;
          sb = b;
          return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // Called at the negedge after the start edge; ends at the negedge where done should be high
  task automatic finish_op(input string name, input int exp_cyc, input logic [31:0] eh,
                           input logic [31:0] el);
    int cyc;
    bit done_busy;
    cyc = 0;
    done_busy = 1'b0;
    while (bus.busy && cyc < 100) begin
      if (bus.done) done_busy = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({name, " done_while_busy"}, 64'(done_busy), 64'd0);
    check({name, " done"}, 64'(bus.done), 64'd1);
    check({name, " hi"}, 64'(bus.hi), 64'(eh));
    check({name, " lo"}, 64'(bus.lo), 64'(el));
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    bus.mthi = 1'b1; bus.src_a = h;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.src_a = l;
    @(negedge clk);
    bus.mtlo = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp;
    logic [31:0] a, b;
    logic [1:0]  op;
    bit          seen_done, seen_busy;

    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.flush = 1'b0;

    tbl[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
    tbl[4]  = '{2'd3, 32'd5,         32'd0,          32'h0000_0005, 32'hFFFF_FFFF};
    tbl[5]  = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD};
    tbl[6]  = '{2'd2, 32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF};
    tbl[7]  = '{2'd1, 32'h0001_0000, 32'h0001_0000,  32'h0000_0001, 32'h0000_0000};
    tbl[8]  = '{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    tbl[9]  = '{2'd3, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E};
    tbl[10] = '{2'd0, 32'd0,         32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000};
    tbl[11] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'h0000_0003};
    tbl[12] = '{2'd0, 32'd7,         32'hFFFF_FFFD,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[13] = '{2'd3, 32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 32'hFFFF_FFFF};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    // Directed vectors; the first one starts on the very first edge after release
    for (int i = 0; i < 14; i++) begin
      if (i != 0) @(negedge clk);
      launch(tbl[i].op, tbl[i].a, tbl[i].b);
      finish_op($sformatf("vec%0d", i), 33, tbl[i].hi, tbl[i].lo);
      @(negedge clk);
      check($sformatf("vec%0d done_one_cycle", i), 64'(bus.done), 64'd0);
    end

    // mthi and mtlo together, no done
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.src_a = 32'h77;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mt_both hi", 64'(bus.hi), 64'h77);
    check("mt_both lo", 64'(bus.lo), 64'h77);
    check("mt_both done", 64'(bus.done), 64'd0);

    // start wins over mthi/mtlo
    write_hilo(32'h1111, 32'h2222);
    bus.mthi = 1'b1; bus.mtlo = 1'b1;
    launch(2'd1, 32'd3, 32'd5);
    check("start_wins hi", 64'(bus.hi), 64'h1111);
    check("start_wins lo", 64'(bus.lo), 64'h2222);
    finish_op("start_wins", 33, 32'd0, 32'd15);

    // DIVU 5/0 with mthi attempted while busy
    @(negedge clk);
    launch(2'd3, 32'd5, 32'd0);
    bus.mthi = 1'b1; bus.src_a = 32'h1234;
    repeat (3) @(negedge clk);
    bus.mthi = 1'b0;
    finish_op("divu_by0_mthi", 30, 32'd5, 32'hFFFF_FFFF);

    // Flush in busy cycle 10
    write_hilo(32'hAAAA, 32'h5555);
    launch(2'd3, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen_done = 1'b1;
      @(negedge clk);
    end
    check("flush no_done", 64'(seen_done), 64'd0);
    check("flush hi", 64'(bus.hi), 64'hAAAA);
    check("flush lo", 64'(bus.lo), 64'h5555);

    // Flush in IDLE blocks start and mthi
    bus.flush = 1'b1; bus.start = 1'b1; bus.mthi = 1'b1; bus.src_a = 32'hDEAD;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0; bus.mthi = 1'b0;
    check("flush_idle busy", 64'(bus.busy), 64'd0);
    check("flush_idle hi", 64'(bus.hi), 64'hAAAA);

    // Back-to-back: start while done is high
    @(negedge clk);
    launch(2'd3, 32'd100, 32'd7);
    finish_op("b2b_first", 33, 32'd2, 32'd14);
    launch(2'd0, 32'hFFFF_FFFD, 32'd7);
    check("b2b accepted", 64'(bus.busy), 64'd1);
    finish_op("b2b_second", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      exp = model(op, a, b);
      @(negedge clk);
      launch(op, a, b);
      finish_op($sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b), 33, exp[63:32], exp[31:0]);
    end

    // Asynchronous reset in the middle of a multiply
    write_hilo(32'hBEEF, 32'hCAFE);
    launch(2'd0, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst hi", 64'(bus.hi), 64'd0);
    check("async_rst lo", 64'(bus.lo), 64'd0);
    check("async_rst busy", 64'(bus.busy), 64'd0);
    check("async_rst done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen_done = 1'b1;
      if (bus.busy) seen_busy = 1'b1;
      @(negedge clk);
    end
    check("post_rst no_done", 64'(seen_done), 64'd0);
    check("post_rst no_busy", 64'(seen_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
